// File: rtl/timer_pkg.sv
// Shared definitions for the timer interrupt controller: register offsets, ICR fields,
// FSM encoding and source indices.
package timer_pkg;

  localparam logic [2:0] IER_OFF = 3'd0;
  localparam logic [2:0] IPR_OFF = 3'd1;
  localparam logic [2:0] ISR_OFF = 3'd2;
  localparam logic [2:0] IVR_OFF = 3'd3;
  localparam logic [2:0] ICR_OFF = 3'd4;

  localparam int unsigned ICR_GIE = 0;
  localparam int unsigned ICR_LVL = 1;

  localparam int unsigned SRC_OVF = 0;
  localparam int unsigned SRC_UDF = 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAssert = 2'd1,
    StGap    = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of the request vector.
module irq_prio_enc #(
  parameter int unsigned NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [2:0]         idx_o,
  output logic               valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = 3'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt controller: edge-detects timer status flags, latches pending bits, masks,
// prioritises and drives a single irq line with vector. Zero-wait-state 8-bit APB slave.
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 2,
  parameter logic [7:0]  BASE_ADDR = 8'h10
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [7:0]         paddr,
  input  logic [7:0]         pwdata,
  output logic [7:0]         prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic [NUM_SRC-1:0] src_lvl,
  output logic               irq,
  output logic [2:0]         irq_vec
);

  // Registers are kept 8 bits wide; bits at or above NUM_SRC are masked to constant zero.
  localparam logic [7:0] SrcMask = 8'((16'd1 << NUM_SRC) - 16'd1);

  logic [7:0] off;
  logic       in_win, access, wr_en, rd_en;
  logic [2:0] reg_sel;

  logic [7:0] ier_q, ier_d, ipr_q, ipr_d, src_q, src_w, set_req, clr, isr;
  logic       gie_q, gie_d, lvl_q, lvl_d;

  irq_state_e state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [2:0] pri_idx;
  logic       pri_valid;

  assign off     = paddr - BASE_ADDR;
  assign in_win  = (off[7:3] == 5'd0);
  assign reg_sel = off[2:0];
  assign access  = psel & penable & in_win;
  assign wr_en   = access & pwrite;
  assign rd_en   = access & ~pwrite;
  assign pready  = 1'b1;

  assign src_w = 8'(src_lvl);
  assign isr   = ipr_q & ier_q;

  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    case (reg_sel)
      IER_OFF: prdata = ier_q;
      IPR_OFF: prdata = ipr_q;
      ISR_OFF: prdata = isr;
      IVR_OFF: prdata = {5'b0, vec_q};
      ICR_OFF: prdata = {6'b0, lvl_q, gie_q};
      default: pslverr = access;
    endcase
    if (!rd_en) prdata = '0;
  end

  always_comb begin
    ier_d = ier_q;
    gie_d = gie_q;
    lvl_d = lvl_q;
    clr   = '0;
    if (wr_en) begin
      case (reg_sel)
        IER_OFF: ier_d = pwdata & SrcMask;
        IPR_OFF: clr = pwdata;
        ICR_OFF: begin
          gie_d = pwdata[ICR_GIE];
          lvl_d = pwdata[ICR_LVL];
        end
        default: ;
      endcase
    end
    set_req = lvl_q ? src_w : (src_w & ~src_q);
    // A new set in the same cycle as a W1C wins, so the event is not lost.
    ipr_d = ((ipr_q & ~clr) | set_req) & SrcMask;
  end

  irq_prio_enc #(
    .NUM_SRC(NUM_SRC)
  ) u_prio (
    .req_i  (isr[NUM_SRC-1:0]),
    .idx_o  (pri_idx),
    .valid_o(pri_valid)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    unique case (state_q)
      StIdle: begin
        if (gie_q && pri_valid) begin
          state_d = StAssert;
          vec_d   = pri_idx;
        end
      end
      StAssert: begin
        // No preemption: only the serviced source's own status can end the request.
        if (!ipr_q[vec_q] || !ier_q[vec_q] || !gie_q) state_d = StGap;
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      ier_q   <= '0;
      ipr_q   <= '0;
      src_q   <= '0;
      gie_q   <= 1'b0;
      lvl_q   <= 1'b0;
      state_q <= StIdle;
      vec_q   <= '0;
    end else begin
      ier_q   <= ier_d;
      ipr_q   <= ipr_d;
      src_q   <= src_w;
      gie_q   <= gie_d;
      lvl_q   <= lvl_d;
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  assign irq     = (state_q == StAssert);
  assign irq_vec = vec_q;

endmodule
